// File: rtl/seq_pkg.sv
// Shared definitions for the pattern sequencer: FSM state encoding and a
// width helper used for index and channel-select fields.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  // Ceiling log2, never below 1 so a single-entry range still gets a 1-bit field.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step-duration countdown: loads P+S for even steps or P-S for odd steps and
// flags expiry on the last cycle of the step while not held.
module step_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         hold,
  input  logic         even,
  input  logic [W-1:0] p,
  input  logic [W-1:0] s,
  output logic         expire
);

  localparam logic [W:0] ONE = (W + 1)'(1);

  logic [W:0] dur;
  logic [W:0] cnt_q;
  logic [W:0] cnt_d;

  // One extra bit keeps P+S from wrapping; S <= P/2 keeps P-S >= 1.
  always_comb begin
    dur   = even ? ({1'b0, p} + {1'b0, s}) : ({1'b0, p} - {1'b0, s});
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = dur - ONE;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = !hold && (cnt_q == '0);

endmodule

// File: rtl/pattern_sequencer.sv
// Multi-channel step sequencer: walks per-channel bit patterns at a
// swing-adjusted rate and emits registered one-cycle trigger pulses.
module pattern_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int NUM_STEPS = 8,
  parameter int PERIOD_W  = 26
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         pause,
  input  logic                         loop_mode,
  input  logic [PERIOD_W-1:0]          period,
  input  logic [PERIOD_W-1:0]          swing,
  input  logic [NUM_CH-1:0]            mute,
  input  logic                         wr_en,
  input  logic [clog2(NUM_CH)-1:0]     wr_ch,
  input  logic [NUM_STEPS-1:0]         wr_pattern,
  output logic [NUM_CH-1:0]            trig,
  output logic [clog2(NUM_STEPS)-1:0]  step_idx,
  output logic                         step_pulse,
  output logic                         playing,
  output logic                         done
);

  localparam int CH_W = clog2(NUM_CH);
  localparam int SW   = clog2(NUM_STEPS);
  localparam logic [SW-1:0]       LAST_STEP = SW'(NUM_STEPS - 1);
  localparam logic [SW-1:0]       ONE_S     = SW'(1);
  localparam logic [PERIOD_W-1:0] ONE_P     = PERIOD_W'(1);

  logic                 rst_meta_q;
  logic                 rst_n_q;
  seq_state_e           state_q, state_d;
  logic [SW-1:0]        idx_q, idx_d;
  logic [NUM_CH-1:0]    trig_q, trig_d;
  logic                 pulse_q;
  logic                 done_q, done_d;
  logic                 playing_q;
  logic                 loop_q, loop_d;
  logic [PERIOD_W-1:0]  p_q, p_d, s_q, s_d;
  logic [PERIOD_W-1:0]  p_new, s_new;
  logic [NUM_STEPS-1:0] pat_q [NUM_CH];
  logic                 fire;
  logic                 expire;
  logic                 last_step;

  // Assertion is immediate; release is re-timed to clk through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  always_comb begin
    p_new = (period == '0) ? ONE_P : period;
    s_new = (swing > (p_new >> 1)) ? (p_new >> 1) : swing;
  end

  assign last_step = (idx_q == LAST_STEP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    fire    = 1'b0;
    loop_d  = loop_q;
    p_d     = p_q;
    s_d     = s_q;
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
            idx_d   = '0;
            fire    = 1'b1;
            loop_d  = loop_mode;
            p_d     = p_new;
            s_d     = s_new;
          end
        end
        ST_RUN: begin
          if (pause) state_d = ST_HOLD;
          // A step boundary coinciding with pause still fires; the hold starts after it.
          if (expire) begin
            if (last_step && !loop_q) begin
              state_d = ST_IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = last_step ? '0 : (idx_q + ONE_S);
              fire  = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pattern bits are read before this edge's write lands, so a coincident write is seen next step.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_trig
      assign trig_d[gi] = fire & pat_q[gi][idx_d] & ~mute[gi];
    end
  endgenerate

  step_timer #(
    .W(PERIOD_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n_q),
    .load  (fire),
    .hold  (state_q != ST_RUN),
    .even  (~idx_d[0]),
    .p     (p_d),
    .s     (s_d),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      for (int c = 0; c < NUM_CH; c++) pat_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en && (wr_ch == CH_W'(c))) pat_q[c] <= wr_pattern;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      trig_q    <= '0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      playing_q <= 1'b0;
      loop_q    <= 1'b0;
      p_q       <= ONE_P;
      s_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      trig_q    <= trig_d;
      pulse_q   <= fire;
      done_q    <= done_d;
      playing_q <= (state_d != ST_IDLE);
      loop_q    <= loop_d;
      p_q       <= p_d;
      s_q       <= s_d;
    end
  end

  assign trig       = trig_q;
  assign step_idx   = idx_q;
  assign step_pulse = pulse_q;
  assign playing    = playing_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: expected step events are queued as
// stimulus is driven and matched against every observed step_pulse.
module tb_pattern_sequencer;

  localparam int NUM_CH    = 4;
  localparam int NUM_STEPS = 8;
  localparam int PERIOD_W  = 26;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 pause = 1'b0;
  logic                 loop_mode = 1'b0;
  logic [PERIOD_W-1:0]  period = '0;
  logic [PERIOD_W-1:0]  swing = '0;
  logic [NUM_CH-1:0]    mute = '0;
  logic                 wr_en = 1'b0;
  logic [1:0]           wr_ch = '0;
  logic [NUM_STEPS-1:0] wr_pattern = '0;
  logic [NUM_CH-1:0]    trig;
  logic [2:0]           step_idx;
  logic                 step_pulse;
  logic                 playing;
  logic                 done;

  typedef struct {
    int                cyc;
    int                idx;
    logic [NUM_CH-1:0] trig;
  } ev_t;

  ev_t                  exp_q[$];
  logic [NUM_STEPS-1:0] mdl_pat [NUM_CH];
  int                   cyc = 0;
  int                   n_checks = 0;
  int                   n_fail = 0;
  bit                   mon_en = 1'b0;

  pattern_sequencer #(
    .NUM_CH   (NUM_CH),
    .NUM_STEPS(NUM_STEPS),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_mode (loop_mode),
    .period    (period),
    .swing     (swing),
    .mute      (mute),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_pattern(wr_pattern),
    .trig      (trig),
    .step_idx  (step_idx),
    .step_pulse(step_pulse),
    .playing   (playing),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit at cyc=%0d", cyc);
    $fatal(1);
  end

  // Scoreboard: every step_pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (step_pulse === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step cyc=%0d got idx=%0d trig=%b, required no step", cyc, step_idx, trig);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          $display("step cyc=%0d idx=%0d trig=%b (expected cyc=%0d idx=%0d trig=%b)",
                   cyc, step_idx, trig, e.cyc, e.idx, e.trig);
          if (cyc != e.cyc || int'(step_idx) != e.idx || trig !== e.trig) begin
            n_fail++;
            $display("FAIL step_event got cyc=%0d idx=%0d trig=%b, required cyc=%0d idx=%0d trig=%b",
                     cyc, step_idx, trig, e.cyc, e.idx, e.trig);
          end
        end
      end else begin
        n_checks++;
        if (trig !== '0) begin
          n_fail++;
          $display("FAIL trig_without_step cyc=%0d got trig=%b, required 0", cyc, trig);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          n_fail++;
          $display("FAIL missed_step cyc=%0d got no step, required idx=%0d at cyc=%0d",
                   cyc, exp_q[0].idx, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic write_pat(input int ch, input logic [NUM_STEPS-1:0] pat);
    wr_en      = 1'b1;
    wr_ch      = 2'(ch);
    wr_pattern = pat;
    tick();
    wr_en      = 1'b0;
    mdl_pat[ch] = pat;
  endtask

  task automatic do_start(input logic lm, input int per, input int sw);
    loop_mode = lm;
    period    = PERIOD_W'(per);
    swing     = PERIOD_W'(sw);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    tick();
    pause = 1'b0;
  endtask

  function automatic logic [NUM_CH-1:0] exp_trig(input int idx);
    logic [NUM_CH-1:0] t;
    for (int c = 0; c < NUM_CH; c++) t[c] = mdl_pat[c][idx] & ~mute[c];
    return t;
  endfunction

  function automatic int gap(input int idx, input int per, input int sw);
    int p;
    int s;
    p = (per < 1) ? 1 : per;
    s = (sw > p / 2) ? p / 2 : sw;
    return (idx % 2 == 0) ? p + s : p - s;
  endfunction

  task automatic push_steps(input int first, input int n, input int per, input int sw, output int last_c);
    int c;
    ev_t e;
    c = first;
    last_c = first;
    for (int i = 0; i < n; i++) begin
      e.cyc  = c;
      e.idx  = i % NUM_STEPS;
      e.trig = exp_trig(i % NUM_STEPS);
      exp_q.push_back(e);
      last_c = c;
      c += gap(i % NUM_STEPS, per, sw);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (trig !== 4'b0) begin n_fail++; $display("FAIL reset_trig got %b, required 0", trig); end
    n_checks++; if (step_idx !== 3'd0) begin n_fail++; $display("FAIL reset_step_idx got %0d, required 0", step_idx); end
    n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_step_pulse got %b, required 0", step_pulse); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing got %b, required 0", playing); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b, required 0", done); end
    reset = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < NUM_CH; c++) mdl_pat[c] = '0;
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL post_reset_playing got %b, required 0", playing); end
    mon_en = 1'b1;
  endtask

  task automatic test_loop();
    int last_c;
    write_pat(0, 8'b0101_0101);
    write_pat(1, 8'b1000_0001);
    write_pat(2, 8'b0000_0000);
    write_pat(3, 8'b0011_1100);
    do_start(1'b1, 4, 0);
    n_checks++;
    if (step_pulse !== 1'b1 || step_idx !== 3'd0 || playing !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency got pulse=%b idx=%0d playing=%b, required 1/0/1", step_pulse, step_idx, playing);
    end
    push_steps(cyc, 10, 4, 0, last_c);
    wait_cyc(last_c + 2);
    do_stop();
    n_checks++;
    if (done !== 1'b1 || step_idx !== 3'd0 || playing !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_stop got done=%b idx=%0d playing=%b, required 1/0/0", done, step_idx, playing);
    end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b, required 0", done); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL loop_pending got %0d events left, required 0", exp_q.size()); end
  endtask

  task automatic test_swing();
    int per_tab[4] = '{10, 10, 0, 1};
    int sw_tab[4]  = '{3, 9, 0, 5};
    int last_c;
    for (int t = 0; t < 4; t++) begin
      do_start(1'b1, per_tab[t], sw_tab[t]);
      push_steps(cyc, 6, per_tab[t], sw_tab[t], last_c);
      wait_cyc(last_c);
      do_stop();
      n_checks++;
      if (done !== 1'b1 || playing !== 1'b0) begin
        n_fail++;
        $display("FAIL swing_stop case=%0d got done=%b playing=%b, required 1/0", t, done, playing);
      end
      repeat (3) tick();
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL swing_pending case=%0d got %0d events left, required 0", t, exp_q.size());
      end
    end
  endtask

  task automatic test_oneshot();
    int first;
    int last_c;
    do_start(1'b0, 2, 0);
    first = cyc;
    push_steps(first, 8, 2, 0, last_c);
    wait_cyc(first + 15);
    n_checks++;
    if (playing !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_before_end got playing=%b done=%b, required 1/0", playing, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || playing !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_done got done=%b playing=%b at cyc=%0d, required 1/0 at cyc=%0d", done, playing, cyc, first + 16);
    end
    repeat (10) tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL oneshot_done_width got %b, required 0", done); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL oneshot_pending got %0d events left, required 0", exp_q.size()); end
  endtask

  task automatic test_pause();
    int s0;
    int last_c;
    int hold_len;
    ev_t e;
    do_pause();
    n_checks++;
    if (playing !== 1'b0 || step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_in_idle got playing=%b pulse=%b, required 0/0", playing, step_pulse);
    end
    do_start(1'b1, 10, 0);
    s0 = cyc;
    push_steps(s0, 4, 10, 0, last_c);
    wait_cyc(s0 + 14);
    do_start(1'b1, 3, 1);
    wait_cyc(s0 + 32);
    do_pause();
    n_checks++;
    if (playing !== 1'b1 || step_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL hold_entry got playing=%b idx=%0d, required 1/3", playing, step_idx);
    end
    wait_cyc(s0 + 52);
    n_checks++;
    if (playing !== 1'b1 || step_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL hold_frozen got playing=%b idx=%0d, required 1/3", playing, step_idx);
    end
    do_pause();
    hold_len = 20;
    e.cyc = s0 + 40 + hold_len; e.idx = 4; e.trig = exp_trig(4); exp_q.push_back(e);
    e.cyc = s0 + 50 + hold_len; e.idx = 5; e.trig = exp_trig(5); exp_q.push_back(e);
    wait_cyc(s0 + 50 + hold_len);
    do_stop();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pause_stop_done got %b, required 1", done); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pause_pending got %0d events left, required 0", exp_q.size()); end
  endtask

  task automatic test_stop();
    int s0;
    int last_c;
    loop_mode = 1'b1;
    period    = PERIOD_W'(2);
    start     = 1'b1;
    stop      = 1'b1;
    tick();
    start     = 1'b0;
    stop      = 1'b0;
    n_checks++;
    if (playing !== 1'b0 || step_pulse !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle got playing=%b pulse=%b done=%b, required 0/0/0", playing, step_pulse, done);
    end
    tick();
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL start_stop_idle_later got playing=%b, required 0", playing); end
    do_start(1'b1, 2, 0);
    s0 = cyc;
    push_steps(s0, 3, 2, 0, last_c);
    wait_cyc(s0 + 4);
    do_pause();
    n_checks++;
    if (playing !== 1'b1 || step_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL stop_hold_entry got playing=%b idx=%0d, required 1/2", playing, step_idx);
    end
    repeat (3) tick();
    do_stop();
    n_checks++;
    if (done !== 1'b1 || step_idx !== 3'd0 || playing !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_in_hold got done=%b idx=%0d playing=%b, required 1/0/0", done, step_idx, playing);
    end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stop_pending got %0d events left, required 0", exp_q.size()); end
  endtask

  task automatic test_mute_write();
    int s0;
    int fire_c;
    int idx;
    ev_t e;
    write_pat(0, 8'b0101_0101);
    write_pat(1, 8'b1000_0001);
    write_pat(2, 8'b0011_1100);
    write_pat(3, 8'b1100_0011);
    mute = 4'b0010;
    do_start(1'b1, 3, 0);
    s0 = cyc;
    e.cyc = s0; e.idx = 0; e.trig = exp_trig(0); exp_q.push_back(e);
    for (int i = 1; i < 12; i++) begin
      fire_c = s0 + 3 * i;
      idx = i % NUM_STEPS;
      wait_cyc(fire_c - 1);
      if (i == 9) mute = 4'b0000;
      e.cyc = fire_c; e.idx = idx; e.trig = exp_trig(idx); exp_q.push_back(e);
      if (i == 2 || i == 7) begin
        wr_en      = 1'b1;
        wr_ch      = (i == 2) ? 2'd0 : 2'd1;
        wr_pattern = (i == 2) ? 8'h00 : 8'hFF;
      end
      tick();
      if (i == 2) begin wr_en = 1'b0; mdl_pat[0] = 8'h00; end
      if (i == 7) begin
        wr_en = 1'b0;
        mdl_pat[1] = 8'hFF;
        n_checks++;
        if (step_pulse !== 1'b1 || trig[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL muted_ch1 got pulse=%b trig1=%b, required 1/0", step_pulse, trig[1]);
        end
      end
    end
    tick();
    do_stop();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mute_stop_done got %b, required 1", done); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mute_pending got %0d events left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    int s0;
    int last_c;
    mute = 4'b0000;
    write_pat(0, 8'hFF);
    do_start(1'b1, 5, 0);
    s0 = cyc;
    push_steps(s0, 3, 5, 0, last_c);
    wait_cyc(s0 + 14);
    tick();
    n_checks++;
    if (step_pulse !== 1'b1 || trig[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_step got pulse=%b trig0=%b, required 1/1", step_pulse, trig[0]);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (trig !== 4'b0) begin n_fail++; $display("FAIL async_trig got %b, required 0", trig); end
    n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL async_step_pulse got %b, required 0", step_pulse); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL async_playing got %b, required 0", playing); end
    n_checks++; if (step_idx !== 3'd0) begin n_fail++; $display("FAIL async_step_idx got %0d, required 0", step_idx); end
    for (int c = 0; c < NUM_CH; c++) mdl_pat[c] = '0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    do_start(1'b1, 2, 0);
    push_steps(cyc, 8, 2, 0, last_c);
    wait_cyc(last_c + 1);
    do_stop();
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cleared_pending got %0d events left, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_swing();
    test_oneshot();
    test_pause();
    test_stop();
    test_mute_write();
    test_reset_mid_run();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of instrument channels (1..16).
REQ-002 The block SHALL have parameter NUM_STEPS, default 8, meaning steps per pattern (2..64).
REQ-003 The block SHALL have parameter PERIOD_W, default 26, meaning width of step-period and swing counts in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the system clock; it is the only clock.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, meaning a one-cycle pulse that begins playback.
REQ-007 The block SHALL have port stop, input, 1 bit, meaning a one-cycle pulse that halts playback.
REQ-008 The block SHALL have port pause, input, 1 bit, meaning a one-cycle pulse that toggles RUN/HOLD.
REQ-009 The block SHALL have port loop_mode, input, 1 bit, meaning 1 = loop and 0 = one-shot; it is sampled on start.
REQ-010 The block SHALL have port period, input, PERIOD_W bits, meaning the nominal step length in clk cycles; it is sampled on start.
REQ-011 The block SHALL have port swing, input, PERIOD_W bits, meaning the swing offset in cycles; it is sampled on start.
REQ-012 The block SHALL have port mute, input, NUM_CH bits, meaning per-channel trigger suppression; it is live.
REQ-013 The block SHALL have port wr_en, input, 1 bit, meaning pattern write strobe.
REQ-014 The block SHALL have port wr_ch, input, clog2(NUM_CH) bits, meaning the channel to write.
REQ-015 The block SHALL have port wr_pattern, input, NUM_STEPS bits, meaning the step bits to write, with bit i = step i.
REQ-016 The block SHALL have port trig, output, NUM_CH bits, meaning one-cycle hit pulses.
REQ-017 The block SHALL have port step_idx, output, clog2(NUM_STEPS) bits, meaning the current step.
REQ-018 The block SHALL have port step_pulse, output, 1 bit, meaning a one-cycle pulse at each step start.
REQ-019 The block SHALL have port playing, output, 1 bit, meaning high in RUN or HOLD.
REQ-020 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse when one-shot playback completes or stop is accepted.

Function
REQ-021 The block SHALL use FSM states IDLE, RUN and HOLD.
REQ-022 On start in IDLE, the next cycle SHALL enter RUN with step_idx=0, and step_pulse and trig SHALL fire for step 0 in that cycle (1-cycle latency).
REQ-023 trig[c] SHALL equal pattern[c][step_idx] AND NOT mute[c], and SHALL be asserted only in step_pulse cycles.
REQ-024 Step duration SHALL be P+S for even step_idx and P-S for odd step_idx, where P = max(period,1) and S = min(swing, P/2) using integer division.
REQ-025 In loop mode, step NUM_STEPS-1 SHALL wrap to 0.
REQ-026 In one-shot mode, the end of step NUM_STEPS-1 SHALL enter IDLE, pulse done, and produce no further step_pulse.
REQ-027 Pause in RUN SHALL enter HOLD and freeze the duration counter and step_idx.
REQ-028 Pause in HOLD SHALL resume RUN without re-firing the current step.
REQ-029 Stop in RUN or HOLD SHALL enter IDLE the next cycle, pulse done, and set step_idx=0.
REQ-030 start in RUN or HOLD SHALL be ignored.
REQ-031 pause in IDLE SHALL be ignored.
REQ-032 When events coincide, priority SHALL be stop > start > pause.
REQ-033 A write SHALL update pattern[wr_ch] at the clock edge.
REQ-034 A step firing in the same cycle as a write to its channel SHALL use the old bits.
REQ-035 Writes SHALL be accepted in every state.
REQ-036 wr_ch >= NUM_CH SHALL be ignored.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 Asserting reset SHALL asynchronously force IDLE, clear all pattern memory to 0, and set trig=0, step_idx=0, step_pulse=0, playing=0 and done=0.
REQ-039 Reset SHALL be released synchronously to clk.
REQ-040 Reset during RUN SHALL suppress any pending trig.

Structure
REQ-041 FSM state encoding and a clog2 helper SHALL reside in shared package seq_pkg.
REQ-042 The step-duration countdown with swing SHALL be one sub-module, step_timer (inputs: load, hold, even, P, S; output: expire).
REQ-043 Pattern storage SHALL be flip-flops; no RAM inference SHALL be used.

Verification
REQ-044 Write ch0=8'b0101_0101 and ch1=8'b1000_0001, period=4, swing=0, loop, then start -> step_pulse every 4 cycles; trig[0] on steps 0,2,4,6; trig[1] on steps 0,7; step wraps 7->0.
REQ-045 period=10, swing=3 -> gap after even steps 13 cycles and after odd steps 7 cycles; swing=9 -> clamped to 5, giving 15/5.
REQ-046 One-shot with period=2 -> exactly 8 step_pulses, done pulses 16 cycles after the first, playing drops, and no trig follows.
REQ-047 Pause at step 3 mid-count for 20 cycles, then pause -> no step_pulse while held, and the remaining count resumes exactly.
REQ-048 start and stop in the same cycle in IDLE -> stays IDLE; stop during HOLD -> done pulse and step_idx=0.
REQ-049 mute=4'b0010 plus a write to ch1 on its firing cycle -> trig[1] never asserted, and the old bits are used on that step.
REQ-050 Async reset mid-RUN -> outputs immediately 0 and pattern cleared.
